// File: rtl/perf_window_scheduler.sv
// Windowed busy-cycle monitor. A counting FSM accumulates per-channel busy
// cycles over back-to-back windows of window_len cycles. At each window end
// the counts are snapshotted and a compute FSM turns each one into a 0..100
// utilization percentage with a bit-serial restoring divider. Results are
// emitted one channel at a time.
//
// Handshake: a result is transferred in every cycle where util_valid and
// util_ready are both high. While util_valid is high, util_ch and util_pct
// hold steady until that transfer. util_valid never depends combinationally
// on util_ready.
module perf_window_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CW     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic [CW-1:0]             window_len,
  input  logic [NUM_CH-1:0]         busy,
  output logic                      util_valid,
  input  logic                      util_ready,
  output logic [$clog2(NUM_CH)-1:0] util_ch,
  output logic [6:0]                util_pct,
  output logic                      running,
  output logic                      window_done,
  output logic                      overrun,
  output logic                      cfg_err,
  output logic                      dbg_cnt_state,
  output logic [1:0]                dbg_cmp_state
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int NW  = CW + 7;

  localparam logic       S_IDLE  = 1'b0;
  localparam logic       S_COUNT = 1'b1;
  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_DIV   = 2'd1;
  localparam logic [1:0] C_OUT   = 2'd2;

  logic            state_q, state_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CW-1:0]   busy_cnt_q [NUM_CH];
  logic [CW-1:0]   busy_cnt_d [NUM_CH];
  logic [CW-1:0]   busy_inc   [NUM_CH];
  logic [CW-1:0]   snap_q     [NUM_CH];
  logic [CW-1:0]   snap_d     [NUM_CH];
  logic            window_done_q, window_done_d;
  logic            overrun_q, overrun_d;
  logic            cfg_err_q, cfg_err_d;
  logic            win_end;

  logic [1:0]      c_state_q, c_state_d;
  logic [CW-1:0]   div_len_q, div_len_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [2:0]      div_cnt_q, div_cnt_d;
  logic [NW-1:0]   rem_q, rem_d;
  logic [6:0]      quo_q, quo_d;
  logic [6:0]      pct_q, pct_d;
  logic [NW-1:0]   trial;
  logic [2:0]      sh;

  // Counting FSM: window sequencing, per-channel accumulation, start/stop.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cycle_cnt_d   = cycle_cnt_q;
    window_done_d = 1'b0;
    cfg_err_d     = cfg_err_q;
    win_end       = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_inc[i]   = busy_cnt_q[i] + CW'(busy[i]);
      busy_cnt_d[i] = busy_cnt_q[i];
    end
    case (state_q)
      S_IDLE: begin
        // stop in the same cycle suppresses start entirely
        if (start && !stop) begin
          if (window_len == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d     = S_COUNT;
            len_d       = window_len;
            cycle_cnt_d = '0;
            for (int i = 0; i < NUM_CH; i++) busy_cnt_d[i] = '0;
          end
        end
      end
      default: begin
        if (stop) begin
          // partial window is dropped: no snapshot, no window_done
          state_d     = S_IDLE;
          cycle_cnt_d = '0;
          for (int i = 0; i < NUM_CH; i++) busy_cnt_d[i] = '0;
        end else if (cycle_cnt_q == len_q - CW'(1)) begin
          win_end       = 1'b1;
          window_done_d = 1'b1;
          cycle_cnt_d   = '0;
          for (int i = 0; i < NUM_CH; i++) busy_cnt_d[i] = '0;
        end else begin
          cycle_cnt_d = cycle_cnt_q + CW'(1);
          for (int i = 0; i < NUM_CH; i++) busy_cnt_d[i] = busy_inc[i];
        end
      end
    endcase
  end

  // Compute FSM: snapshot capture, restoring division, result handshake.
  always_comb begin
    c_state_d = c_state_q;
    div_len_d = div_len_q;
    ch_d      = ch_q;
    div_cnt_d = div_cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    pct_d     = pct_q;
    sh        = 3'd7 - div_cnt_q;
    trial     = NW'(div_len_q) << sh;
    for (int i = 0; i < NUM_CH; i++) snap_d[i] = snap_q[i];
    // a window ending while a result set is still in flight is lost
    overrun_d = overrun_q | (win_end && (c_state_q != C_IDLE));
    case (c_state_q)
      C_IDLE: begin
        if (win_end) begin
          for (int i = 0; i < NUM_CH; i++) snap_d[i] = busy_inc[i];
          div_len_d = len_q;
          ch_d      = '0;
          div_cnt_d = '0;
          c_state_d = C_DIV;
        end
      end
      C_DIV: begin
        if (div_cnt_q == 3'd0) begin
          rem_d     = NW'(snap_q[ch_q]) * NW'(100);
          quo_d     = '0;
          div_cnt_d = 3'd1;
        end else begin
          // quotient bit (7 - div_cnt); quotient never exceeds 100 < 2^7
          if (rem_q >= trial) begin
            rem_d = rem_q - trial;
            quo_d = quo_q | (7'd1 << sh);
          end
          if (div_cnt_q == 3'd7) begin
            pct_d     = quo_d;
            c_state_d = C_OUT;
          end else begin
            div_cnt_d = div_cnt_q + 3'd1;
          end
        end
      end
      C_OUT: begin
        if (util_ready) begin
          div_cnt_d = '0;
          if (ch_q == CHW'(NUM_CH - 1)) begin
            c_state_d = C_IDLE;
          end else begin
            ch_d      = ch_q + CHW'(1);
            c_state_d = C_DIV;
          end
        end
      end
      default: c_state_d = C_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      cycle_cnt_q   <= '0;
      window_done_q <= 1'b0;
      overrun_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      c_state_q     <= C_IDLE;
      div_len_q     <= '0;
      ch_q          <= '0;
      div_cnt_q     <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      pct_q         <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        busy_cnt_q[i] <= '0;
        snap_q[i]     <= '0;
      end
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cycle_cnt_q   <= cycle_cnt_d;
      window_done_q <= window_done_d;
      overrun_q     <= overrun_d;
      cfg_err_q     <= cfg_err_d;
      c_state_q     <= c_state_d;
      div_len_q     <= div_len_d;
      ch_q          <= ch_d;
      div_cnt_q     <= div_cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      pct_q         <= pct_d;
      for (int i = 0; i < NUM_CH; i++) begin
        busy_cnt_q[i] <= busy_cnt_d[i];
        snap_q[i]     <= snap_d[i];
      end
    end
  end

  assign util_valid    = (c_state_q == C_OUT);
  assign util_ch       = ch_q;
  assign util_pct      = pct_q;
  assign running       = (state_q == S_COUNT);
  assign window_done   = window_done_q;
  assign overrun       = overrun_q;
  assign cfg_err       = cfg_err_q;
  assign dbg_cnt_state = state_q;
  assign dbg_cmp_state = c_state_q;

endmodule

// File: doc/perf_window_scheduler.md
PERF_WINDOW_SCHEDULER -- requirements
Module: perf_window_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of monitored busy channels (2..16).
REQ-002 Parameter CW, default 32: width of window length and per-channel busy counters.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse; begins continuous windowed measurement.
REQ-006 stop  input  1  single-cycle pulse; ends measurement.
REQ-007 window_len  input  CW  window length in cycles; latched when start is accepted.
REQ-008 busy  input  NUM_CH  per-channel busy flags, sampled every counting cycle.
REQ-009 util_valid  output  1  result valid.
REQ-010 util_ready  input  1  consumer accepts result when util_valid and util_ready are both high.
REQ-011 util_ch  output  $clog2(NUM_CH)  channel index of the current result.
REQ-012 util_pct  output  7  utilization, 0..100.
REQ-013 running  output  1  high while windows are being counted.
REQ-014 window_done  output  1  one-cycle pulse at each window end.
REQ-015 overrun  output  1  sticky; a window ended before the previous window's results were drained.
REQ-016 cfg_err  output  1  sticky; start was issued with window_len == 0.

Function
REQ-017 Counting FSM states: IDLE and COUNT.
- IDLE -> COUNT on start with window_len != 0; running rises the next cycle.
REQ-018 In COUNT, cycle_cnt runs 0..L-1, where L is the latched window_len.
- busy[i] high in a counting cycle increments busy_cnt[i].
REQ-019 Window end occurs in the cycle where cycle_cnt == L-1.
- That cycle's busy is included.
- Final counts are copied into snapshot registers.
- Counters clear and the next window begins the following cycle with no gap.
- window_done pulses the following cycle.
REQ-020 Compute FSM states: C_IDLE, C_DIV, C_OUT; it runs concurrently with counting.
- Snapshots are processed in channel order 0..NUM_CH-1.
REQ-021 C_DIV computes util_pct = floor(snap[i]*100 / L).
- Numerator is CW+7 bits wide.
- Restoring division: 1 load cycle plus 7 iteration cycles, 8 cycles per channel.
- No hardware divider.
REQ-022 C_OUT asserts util_valid with a stable util_ch and util_pct until the handshake.
- After the handshake: C_DIV for the next channel, or C_IDLE after the last channel.
REQ-023 Overrun: if a window ends while compute is not in C_IDLE:
- the new snapshot is discarded;
- overrun sets;
- the in-progress result set completes unaffected.
REQ-024 stop while COUNT:
- the current partial window is discarded with no snapshot and no window_done;
- returns to IDLE next cycle;
- in-progress compute continues to completion.
REQ-025 start while already in COUNT is ignored; stop while IDLE is ignored.
REQ-026 If start and stop are asserted in the same cycle, stop wins.
REQ-027 start with window_len == 0:
- is rejected and cfg_err sets;
- the block stays IDLE.
REQ-028 window_len == 1 is legal; every cycle is a window end.
REQ-029 Overrun and cfg_err clear only on reset.
REQ-030 Counters cannot wrap, because busy_cnt[i] <= L <= 2^CW-1.

Reset
REQ-031 Reset forces:
- FSMs to IDLE and C_IDLE;
- all counters and snapshots to 0;
- util_valid, running, window_done, overrun and cfg_err to 0;
- util_ch and util_pct to 0.
REQ-032 Reset mid-window or mid-compute abandons all in-flight results; no util_valid follows reset.
REQ-033 Reset takes priority over start and stop in the same cycle.

Verification
REQ-034 L=10, util_ready=1; busy[0] high 5 of 10 cycles, busy[1] always high, busy[2] never high, busy[3] high 3 cycles.
- Expect window_done once.
- Expect results in order ch0=50, ch1=100, ch2=0, ch3=30.
- Each result arrives 8 cycles after the previous handshake.
REQ-035 L=3, busy[0] high 1 of 3 cycles -> util_pct=33 (floor); L=7, 2 of 7 cycles -> 28.
REQ-036 util_ready held low for 40 cycles with L=10:
- ch0 result is held stable throughout;
- overrun=1 after the next window end;
- the subsequent window's results are emitted normally once drained.
REQ-037 start with window_len=0 -> cfg_err=1, running=0, no util_valid; then start with L=5 -> normal operation, cfg_err stays 1.
REQ-038 stop at cycle_cnt=4 of L=10 -> running=0 next cycle, no window_done, no results.
REQ-039 reset asserted during C_DIV of ch2 -> next cycle all outputs 0, and no further util_valid until a new start plus a full window.
